// File: rtl/pipe_ctrl.sv
// pipe_ctrl: decode and hazard control for a 5-stage MIPS-style pipeline.
// ID decodes combinationally; control words then travel EX -> MEM -> WB one
// stage per cycle. Load-use and mult/div hazards stall ID and bubble EX, and
// a taken branch resolved in EX flushes the instruction sitting in ID.
// There are no valid/ready handshakes here: stall and flush are the only
// flow-control signals, and both are plain combinational levels.
module pipe_ctrl #(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] id_instr,
  input  logic        id_valid,
  input  logic        branch_taken,
  output logic        stall,
  output logic        flush,
  output logic [9:0]  ex_ctrl,
  output logic [9:0]  mem_ctrl,
  output logic [3:0]  ex_alu,
  output logic [4:0]  ex_dest,
  output logic [4:0]  mem_dest,
  output logic [4:0]  wb_dest,
  output logic        wb_reg_write,
  output logic        md_busy,
  output logic        ex_illegal
);

  // Control word bit positions
  localparam int C_JUMP = 0, C_BRANCH = 1, C_MEMW = 2, C_MEMR = 3, C_REGW = 4;
  localparam int C_IMM = 5, C_ZEXT = 6, C_BNE = 7, C_LINK = 8, C_RDST = 9;

  // ALU operation codes
  localparam logic [3:0] ALU_NOP = 4'd0, ALU_ADD = 4'd1, ALU_SUB = 4'd2;
  localparam logic [3:0] ALU_AND = 4'd3, ALU_OR = 4'd4, ALU_XOR = 4'd5;
  localparam logic [3:0] ALU_SLT = 4'd6, ALU_SLTU = 4'd7, ALU_LUI = 4'd8;
  localparam logic [3:0] ALU_FUNC = 4'd9;

  logic [5:0] opc, funct;
  logic [4:0] rs, rt, rd;
  logic       unused_bits;

  assign opc   = id_instr[31:26];
  assign rs    = id_instr[25:21];
  assign rt    = id_instr[20:16];
  assign rd    = id_instr[15:11];
  assign funct = id_instr[5:0];
  // Shift amount and immediate fields are datapath-only.
  assign unused_bits = ^{id_instr[10:6]};

  logic [9:0] d_ctrl;
  logic [3:0] d_alu;
  logic [4:0] d_dest;
  logic       d_legal, d_reads_rt, d_md_op, d_md_use, d_div;

  // ID decode: control word, ALU op, destination and hazard-relevant flags
  always_comb begin
    d_ctrl     = '0;
    d_alu      = ALU_NOP;
    d_dest     = '0;
    d_legal    = 1'b1;
    d_reads_rt = 1'b0;
    d_md_op    = 1'b0;
    d_md_use   = 1'b0;
    d_div      = 1'b0;
    case (opc)
      6'h00: begin
        d_ctrl[C_RDST] = 1'b1;
        d_ctrl[C_REGW] = 1'b1;
        d_alu          = ALU_FUNC;
        d_reads_rt     = 1'b1;
        case (funct)
          6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
          6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
          6'h26, 6'h27, 6'h2A, 6'h2B: ;
          6'h08: begin  // JR
            d_ctrl[C_JUMP] = 1'b1;
            d_ctrl[C_REGW] = 1'b0;
            d_alu          = ALU_NOP;
            d_reads_rt     = 1'b0;
          end
          6'h18, 6'h19, 6'h1A, 6'h1B: begin  // MULT(U), DIV(U)
            d_ctrl[C_REGW] = 1'b0;
            d_md_op        = 1'b1;
            d_md_use       = 1'b1;
            d_div          = funct[1];
          end
          6'h10, 6'h12: begin  // MFHI, MFLO
            d_md_use   = 1'b1;
            d_reads_rt = 1'b0;
          end
          default: d_legal = 1'b0;
        endcase
      end
      6'h02: d_ctrl[C_JUMP] = 1'b1;
      6'h03: begin
        d_ctrl[C_JUMP] = 1'b1;
        d_ctrl[C_LINK] = 1'b1;
        d_ctrl[C_REGW] = 1'b1;
      end
      6'h04: begin
        d_ctrl[C_BRANCH] = 1'b1;
        d_alu            = ALU_SUB;
        d_reads_rt       = 1'b1;
      end
      6'h05: begin
        d_ctrl[C_BRANCH] = 1'b1;
        d_ctrl[C_BNE]    = 1'b1;
        d_alu            = ALU_SUB;
        d_reads_rt       = 1'b1;
      end
      6'h08, 6'h09: begin d_ctrl[C_REGW] = 1'b1; d_ctrl[C_IMM] = 1'b1; d_alu = ALU_ADD;  end
      6'h0A:        begin d_ctrl[C_REGW] = 1'b1; d_ctrl[C_IMM] = 1'b1; d_alu = ALU_SLT;  end
      6'h0B:        begin d_ctrl[C_REGW] = 1'b1; d_ctrl[C_IMM] = 1'b1; d_alu = ALU_SLTU; end
      6'h0C: begin d_ctrl[C_REGW] = 1'b1; d_ctrl[C_IMM] = 1'b1; d_ctrl[C_ZEXT] = 1'b1; d_alu = ALU_AND; end
      6'h0D: begin d_ctrl[C_REGW] = 1'b1; d_ctrl[C_IMM] = 1'b1; d_ctrl[C_ZEXT] = 1'b1; d_alu = ALU_OR;  end
      6'h0E: begin d_ctrl[C_REGW] = 1'b1; d_ctrl[C_IMM] = 1'b1; d_ctrl[C_ZEXT] = 1'b1; d_alu = ALU_XOR; end
      6'h0F:        begin d_ctrl[C_REGW] = 1'b1; d_ctrl[C_IMM] = 1'b1; d_alu = ALU_LUI;  end
      6'h23: begin
        d_ctrl[C_MEMR] = 1'b1;
        d_ctrl[C_REGW] = 1'b1;
        d_ctrl[C_IMM]  = 1'b1;
        d_alu          = ALU_ADD;
      end
      6'h2B: begin
        d_ctrl[C_MEMW] = 1'b1;
        d_ctrl[C_IMM]  = 1'b1;
        d_alu          = ALU_ADD;
        d_reads_rt     = 1'b1;
      end
      default: d_legal = 1'b0;
    endcase
    if (!d_legal) begin
      d_ctrl     = '0;
      d_alu      = ALU_NOP;
      d_reads_rt = 1'b0;
      d_md_op    = 1'b0;
      d_md_use   = 1'b0;
      d_div      = 1'b0;
    end else if (d_ctrl[C_LINK]) begin
      d_dest = 5'd31;
    end else if (d_ctrl[C_RDST]) begin
      d_dest = rd;
    end else begin
      d_dest = rt;
    end
    // Writes to $0 are discarded at the source.
    if (d_dest == 5'd0) d_ctrl[C_REGW] = 1'b0;
  end

  logic       ex_valid;
  logic [5:0] md_cnt;
  logic       load_use, md_hazard, issue;

  assign md_busy   = (md_cnt != 6'd0);
  assign load_use  = ex_valid && ex_ctrl[C_MEMR] && (ex_dest != 5'd0) &&
                     ((ex_dest == rs) || (d_reads_rt && (ex_dest == rt)));
  assign md_hazard = md_busy && d_md_use;
  assign flush     = branch_taken && ex_valid;
  // A flush discards ID anyway, so it overrides any stall request.
  assign stall     = id_valid && (load_use || md_hazard) && !flush;
  assign issue     = id_valid && !stall && !flush;

  // EX stage register: take the decoded ID instruction or a bubble
  always_ff @(posedge clk) begin
    if (!rst_n || !issue) begin
      ex_valid   <= 1'b0;
      ex_ctrl    <= '0;
      ex_alu     <= ALU_NOP;
      ex_dest    <= '0;
      ex_illegal <= 1'b0;
    end else begin
      ex_valid   <= 1'b1;
      ex_ctrl    <= d_ctrl;
      ex_alu     <= d_alu;
      ex_dest    <= d_dest;
      ex_illegal <= !d_legal;
    end
  end

  // MEM and WB stage registers always advance
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_ctrl     <= '0;
      mem_dest     <= '0;
      wb_dest      <= '0;
      wb_reg_write <= 1'b0;
    end else begin
      mem_ctrl     <= ex_ctrl;
      mem_dest     <= ex_dest;
      wb_dest      <= mem_dest;
      wb_reg_write <= mem_ctrl[C_REGW];
    end
  end

  // Mult/div busy counter: loads when a mult/div issues, then counts down to 0
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      md_cnt <= '0;
    end else if (issue && d_md_op) begin
      md_cnt <= d_div ? 6'(DIV_CYCLES) : 6'(MUL_CYCLES);
    end else if (md_cnt != 6'd0) begin
      md_cnt <= md_cnt - 6'd1;
    end
  end

endmodule
